// File: rtl/bcd_display_formatter_pkg.sv
// Shared definitions for the BCD display formatter: default sizing, FSM encodings
// and the helper that derives the largest value representable in DIGITS decimal digits.
package bcd_display_formatter_pkg;

    localparam int unsigned INPUT_WIDTH_DEFAULT = 27;
    localparam int unsigned DIGITS_DEFAULT      = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Returns 10^digits - 1, the saturation threshold for a conversion.
    function automatic longint unsigned max_bcd_value(input int unsigned digits);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_display_formatter_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module bcd_display_formatter_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment controller.
// Outputs only ever change on the completion edge, so the display never sees partial results.
module bcd_display_formatter
    import bcd_display_formatter_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = INPUT_WIDTH_DEFAULT,
    parameter int unsigned DIGITS      = DIGITS_DEFAULT
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [INPUT_WIDTH-1:0] value,
    input  logic [2:0]             pointPosition,
    input  logic                   pointValid,
    input  logic                   start,
    output logic                   ready,
    output logic [4*DIGITS-1:0]    data,
    output logic [DIGITS-1:0]      pointEnable,
    output logic                   dataValid,
    output logic                   overflow
);

    localparam int unsigned     CntW      = $clog2(INPUT_WIDTH + 1);
    localparam int unsigned     BcdW      = 4 * DIGITS;
    localparam longint unsigned MaxValue  = max_bcd_value(DIGITS);
    localparam logic [CntW-1:0] LastShift = CntW'(INPUT_WIDTH - 1);

    logic [1:0]             state_q, state_d;
    logic [INPUT_WIDTH-1:0] shift_q, shift_d;
    logic [BcdW-1:0]        bcd_q, bcd_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   ovf_pending_q, ovf_pending_d;
    logic [2:0]             point_pos_q, point_pos_d;
    logic                   point_valid_q, point_valid_d;
    logic [BcdW-1:0]        data_q, data_d;
    logic [DIGITS-1:0]      point_enable_q, point_enable_d;
    logic                   data_valid_q, data_valid_d;
    logic                   overflow_q, overflow_d;

    logic [BcdW-1:0]        bcd_adj;
    logic [DIGITS-1:0]      point_mask;
    logic                   value_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_display_formatter_add3 u_add3 (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    assign value_ovf = 64'(value) > MaxValue;

    // A point index beyond the last digit simply matches no bit and lights nothing.
    always_comb begin
        point_mask = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            point_mask[i] = point_valid_q && (int'(point_pos_q) == i);
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bcd_d          = bcd_q;
        cnt_d          = cnt_q;
        ovf_pending_d  = ovf_pending_q;
        point_pos_d    = point_pos_q;
        point_valid_d  = point_valid_q;
        data_d         = data_q;
        point_enable_d = point_enable_q;
        overflow_d     = overflow_q;
        data_valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d       = value;
                    bcd_d         = '0;
                    cnt_d         = '0;
                    ovf_pending_d = value_ovf;
                    point_pos_d   = pointPosition;
                    point_valid_d = pointValid;
                    state_d       = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // The bit leaving the top of the accumulator only matters on overflow,
                // and that result is saturated anyway.
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d            = cnt_q + CntW'(1);
                if (cnt_q == LastShift) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                data_d         = ovf_pending_q ? {DIGITS{BCD_NINE}} : bcd_q;
                point_enable_d = point_mask;
                overflow_d     = ovf_pending_q;
                data_valid_d   = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bcd_q          <= '0;
            cnt_q          <= '0;
            ovf_pending_q  <= 1'b0;
            point_pos_q    <= '0;
            point_valid_q  <= 1'b0;
            data_q         <= '0;
            point_enable_q <= '0;
            data_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bcd_q          <= bcd_d;
            cnt_q          <= cnt_d;
            ovf_pending_q  <= ovf_pending_d;
            point_pos_q    <= point_pos_d;
            point_valid_q  <= point_valid_d;
            data_q         <= data_d;
            point_enable_q <= point_enable_d;
            data_valid_q   <= data_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign data        = data_q;
    assign pointEnable = point_enable_q;
    assign dataValid   = data_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench for bcd_display_formatter: directed scenarios plus randomized
// conversions compared against an arithmetic decimal-digit model.
module tb_bcd_display_formatter;

    localparam int unsigned W   = 27;
    localparam int unsigned D   = 8;
    localparam int          LAT = W + 1;
    localparam longint unsigned MAXV = 64'd99_999_999;

    logic           clock = 1'b0;
    logic           resetN = 1'b0;
    logic [W-1:0]   value = '0;
    logic [2:0]     pointPosition = '0;
    logic           pointValid = 1'b0;
    logic           start = 1'b0;
    logic           ready;
    logic [4*D-1:0] data;
    logic [D-1:0]   pointEnable;
    logic           dataValid;
    logic           overflow;

    int check_cnt = 0;
    int fail_cnt  = 0;

    logic [31:0] exp_data = '0;
    logic [7:0]  exp_pe   = '0;
    logic        exp_ovf  = 1'b0;

    bcd_display_formatter #(
        .INPUT_WIDTH (W),
        .DIGITS      (D)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .value         (value),
        .pointPosition (pointPosition),
        .pointValid    (pointValid),
        .start         (start),
        .ready         (ready),
        .data          (data),
        .pointEnable   (pointEnable),
        .dataValid     (dataValid),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0]     r;
        longint unsigned x;
        if (v > MAXV) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_pe(input logic pv, input logic [2:0] pp);
        return pv ? (8'd1 << pp) : 8'd0;
    endfunction

    task automatic convert(input logic [W-1:0] v, input logic pv, input logic [2:0] pp,
                           input bit poke);
        int seen;
        seen = 0;
        @(negedge clock);
        check_eq("ready_idle", 64'(ready), 64'd1);
        value = v;
        pointValid = pv;
        pointPosition = pp;
        start = 1'b1;
        @(posedge clock);
        #1;
        check_eq("ready_busy", 64'(ready), 64'd0);
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= LAT + 8 && seen == 0; n++) begin
            if (poke && n == 5) begin
                start = 1'b1;
                value = W'($urandom);
                pointValid = ~pv;
            end
            if (poke && n == 6) start = 1'b0;
            @(posedge clock);
            #1;
            if (dataValid) seen = n;
            else check_eq("hold_data", 64'(data), 64'(exp_data));
        end
        exp_data = ref_bcd(64'(v));
        exp_pe   = ref_pe(pv, pp);
        exp_ovf  = 64'(v) > MAXV;
        check_eq("latency", 64'(seen), 64'(LAT));
        check_eq("data", 64'(data), 64'(exp_data));
        check_eq("point_enable", 64'(pointEnable), 64'(exp_pe));
        check_eq("overflow", 64'(overflow), 64'(exp_ovf));
        check_eq("ready_after", 64'(ready), 64'd1);
        @(posedge clock);
        #1;
        check_eq("dv_pulse", 64'(dataValid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, 64'(data), 64'd0);
        check_eq({tag, "_pe"}, 64'(pointEnable), 64'd0);
        check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
        check_eq({tag, "_dv"}, 64'(dataValid), 64'd0);
        check_eq({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic reset_mid_conversion();
        int pulses;
        pulses = 0;
        @(negedge clock);
        value = W'(987_654);
        pointValid = 1'b1;
        pointPosition = 3'd4;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        resetN = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_data = '0;
        exp_pe   = '0;
        exp_ovf  = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        for (int n = 0; n < LAT + 6; n++) begin
            @(posedge clock);
            #1;
            if (dataValid) pulses++;
        end
        check_eq("rst_no_dv", 64'(pulses), 64'd0);
        check_eq("rst_data_held", 64'(data), 64'd0);
    endtask

    task automatic continuous_start();
        int hits[$];
        @(negedge clock);
        value = W'(5);
        pointValid = 1'b0;
        start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clock);
            #1;
            if (dataValid) begin
                hits.push_back(n);
                check_eq("cont_data", 64'(data), 64'(ref_bcd(64'd5)));
            end
        end
        @(negedge clock);
        start = 1'b0;
        check_eq("cont_count", 64'(hits.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq("cont_edge", (hits.size() > k) ? 64'(hits[k]) : 64'hFFFF,
                     64'(LAT + k * (LAT + 1)));
        end
        repeat (40) @(posedge clock);
        exp_data = ref_bcd(64'd5);
        exp_pe   = '0;
        exp_ovf  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        #23;
        check_reset_outputs("por");
        @(negedge clock);
        resetN = 1'b1;

        convert(W'(0), 1'b0, 3'd0, 1'b0);
        convert(W'(12_345_678), 1'b1, 3'd2, 1'b0);
        convert(W'(99_999_999), 1'b0, 3'd0, 1'b0);
        convert(W'(100_000_000), 1'b1, 3'd7, 1'b0);
        convert(W'(42), 1'b0, 3'd0, 1'b1);
        reset_mid_conversion();
        convert(W'(7), 1'b0, 3'd0, 1'b0);
        continuous_start();
        convert(W'(2**W - 1), 1'b1, 3'd0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 3))
                0:       v = W'($urandom);
                1:       v = W'($urandom_range(0, 999));
                2:       v = W'($urandom_range(99_999_990, 100_000_010));
                default: v = W'($urandom_range(0, 99_999_999));
            endcase
            convert(v, 1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
